key_step_conditioner: RTL
=========================

// Module: key_step_conditioner
// PURPOSE
//  Input-conditioning stage that sits directly upstream of the sequence-detector FSM.
//  - Synchronises the raw active-low "shift" push-button and the "x" slide switch into CLOCK_50.
//  - Debounces the key and emits one clean single-cycle step pulse per physical press.
//  - Captures x alongside the pulse, so the detector advances once per press on a clocked, glitch-free strobe.
//  - Counts accepted presses, for the board LEDs/HEX.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000  stable cycles required to accept a level change (20 ms @ 50 MHz); legal range >= 2
//  CNT_W            20         debounce counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES
//  SYNC_STAGES      2          synchroniser flops per input; legal range >= 2
// PORTS
//  CLOCK_50    in   1  system clock, 50 MHz
//  rst         in   1  synchronous reset, active-high
//  shift_n     in   1  raw push-button, active-low (0 = pressed), asynchronous
//  x_raw       in   1  raw data switch, asynchronous
//  step        out  1  one-cycle strobe per debounced press
//  x_bit       out  1  x value captured with step; held until the next step
//  key_down    out  1  debounced key level (1 = pressed)
//  step_count  out  8  accepted presses modulo 256
// BEHAVIOUR
//  Reset:
//  - Synchronous reset. step=0, x_bit=0, key_down=0, step_count=0, state=RELEASED, cnt=0.
//  - Key synchroniser flops reset to 1 (released); x synchroniser flops reset to 0.
//  Synchronisers:
//  - key_s and x_s are the outputs of SYNC_STAGES-deep flop chains on shift_n and x_raw.
//  - All FSM logic uses key_s/x_s only.
//  FSM (registered), states RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK:
//  - RELEASED: key_s=0 -> PRESS_CHK, cnt<=0.
//  - PRESS_CHK:
//    - key_s=1 -> RELEASED (bounce rejected, no step).
//    - Else, if cnt==DEBOUNCE_CYCLES-1 -> PRESSED.
//    - Otherwise cnt<=cnt+1.
//  - PRESSED: key_s=1 -> RELEASE_CHK, cnt<=0.
//  - RELEASE_CHK:
//    - key_s=0 -> PRESSED (no new step).
//    - Else, if cnt==DEBOUNCE_CYCLES-1 -> RELEASED.
//    - Otherwise cnt<=cnt+1.
//  - Unreachable encodings -> RELEASED.
//  Outputs (all registered):
//  - step=1 for exactly the one cycle after the PRESS_CHK->PRESSED transition edge. It is never asserted twice without an intervening RELEASED.
//  - x_bit<=x_s on the same edge that sets step, so x_bit is valid while step=1 and stays stable afterwards.
//  - step_count increments on the same edge; 255 wraps to 0.
//  - key_down=1 in PRESSED and RELEASE_CHK, else 0.
//  Latency:
//  - key_s low -> step high = DEBOUNCE_CYCLES+1 cycles.
//  - shift_n low (stable) -> step high = SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles.
//  Boundary conditions:
//  - Glitch shorter than DEBOUNCE_CYCLES cycles: no step, key_down unchanged.
//  - Key held indefinitely: one step only. No auto-repeat.
//  - Release bounce shorter than DEBOUNCE_CYCLES: no extra step.
//  - x changing during debounce: only the x_s value at the accepting edge is captured.
//  - rst mid-debounce or mid-press: immediate return to reset values; no step in the reset cycle.
//  - Key held low through reset: after rst drops, the key is debounced again and yields one step (accepted as a new press).
// STRUCTURE
//  Shared package key_cond_pkg:
//  - State encoding: localparams ST_RELEASED=2'd0, ST_PRESS_CHK=2'd1, ST_PRESSED=2'd2, ST_RELEASE_CHK=2'd3.
//  - Default DEBOUNCE_CYCLES constant, reused by other board-input blocks.
//  One sub-module: sync_ff_chain (parameters STAGES and RESET_VAL), instanced twice (key and x).
//  The FSM, counter and output registers are inline in this module.
// TESTING  (DEBOUNCE_CYCLES=8, SYNC_STAGES=2)
//  1. rst=1 for 3 cycles, then 0 -> step=0, x_bit=0, key_down=0, step_count=0.
//  2. x_raw=1; shift_n 1->0 held 20 cycles -> step high exactly 1 cycle, 11 cycles after the fall; x_bit=1; step_count=1.
//  3. shift_n pulses low 5 cycles, 3 times, separated by 4 high cycles -> no step; step_count unchanged.
//  4. Press accepted, then release with 4-cycle bounce highs, then stable high 20 cycles -> exactly 1 step total; key_down falls 9 cycles after stable high on key_s.
//  5. 256 clean presses -> step_count returns to 0; the 257th press gives step_count=1.
//  6. rst asserted at PRESS_CHK cnt=5 with shift_n held low -> no step during reset; step appears 11 cycles after rst deasserts.

Source files
------------

// File: rtl/key_cond_pkg.sv
// Shared definitions for the board-input conditioning blocks.
// Holds the key debouncer state encoding and the default debounce
// interval (20 ms at 50 MHz) so every board-input block agrees on them.
package key_cond_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

    typedef logic [1:0] key_state_t;

    localparam key_state_t ST_RELEASED    = 2'd0;
    localparam key_state_t ST_PRESS_CHK   = 2'd1;
    localparam key_state_t ST_PRESSED     = 2'd2;
    localparam key_state_t ST_RELEASE_CHK = 2'd3;

    // The key is considered "down" once a press has been accepted and
    // until a release has been fully confirmed.
    function automatic logic state_is_down(input key_state_t st);
        return (st == ST_PRESSED) || (st == ST_RELEASE_CHK);
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser for one asynchronous input bit.
// Ports:
//   clk   - destination clock
//   rst   - synchronous reset, active-high; loads every flop with RESET_VAL
//   d     - asynchronous input
//   q     - synchronised output (STAGES clock edges of latency)
module sync_ff_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the chain; bit 0 is the metastable
    // capture flop, the top bit is the settled output.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/key_step_conditioner.sv
// Input conditioning in front of the sequence detector: synchronises the
// active-low shift key and the x switch, debounces the key, and emits one
// single-cycle step strobe per physical press with x captured alongside.
// Ports:
//   CLOCK_50   - 50 MHz system clock
//   rst        - synchronous reset, active-high
//   shift_n    - raw push-button, active-low, asynchronous
//   x_raw      - raw data switch, asynchronous
//   step       - one-cycle strobe per debounced press
//   x_bit      - x sampled on the step edge, held until the next step
//   key_down   - debounced key level (1 = pressed)
//   step_count - accepted presses modulo 256
module key_step_conditioner
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       shift_n,
    input  logic       x_raw,
    output logic       step,
    output logic       x_bit,
    output logic       key_down,
    output logic [7:0] step_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic key_s;
    logic x_s;

    key_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             step_nx;
    logic             x_bit_nx;
    logic             key_down_nx;
    logic [7:0]       step_count_nx;

    // The key synchroniser resets to the released level so that a reset
    // never looks like a press edge; x resets to 0.
    sync_ff_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_key_sync (
        .clk (CLOCK_50),
        .rst (rst),
        .d   (shift_n),
        .q   (key_s)
    );

    sync_ff_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_x_sync (
        .clk (CLOCK_50),
        .rst (rst),
        .d   (x_raw),
        .q   (x_s)
    );

    // State, counter and output registers.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state      <= ST_RELEASED;
            cnt        <= '0;
            step       <= 1'b0;
            x_bit      <= 1'b0;
            key_down   <= 1'b0;
            step_count <= 8'd0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            step       <= step_nx;
            x_bit      <= x_bit_nx;
            key_down   <= key_down_nx;
            step_count <= step_count_nx;
        end
    end

    // Next-state logic. A level change is accepted only after it has been
    // seen continuously for DEBOUNCE_CYCLES checks; any contrary sample
    // during a check returns to the previous stable state.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_RELEASED: begin
                if (!key_s) begin
                    state_nx = ST_PRESS_CHK;
                    cnt_nx   = '0;
                end
            end
            ST_PRESS_CHK: begin
                if (key_s) begin
                    state_nx = ST_RELEASED;
                end else if (cnt == CNT_LAST) begin
                    state_nx = ST_PRESSED;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (key_s) begin
                    state_nx = ST_RELEASE_CHK;
                    cnt_nx   = '0;
                end
            end
            ST_RELEASE_CHK: begin
                if (!key_s) begin
                    state_nx = ST_PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_nx = ST_RELEASED;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = ST_RELEASED;
                cnt_nx   = '0;
            end
        endcase
    end

    // Output logic. Only the PRESS_CHK -> PRESSED acceptance produces a
    // step, so a held key or a release bounce can never repeat it.
    always_comb begin
        step_nx       = (state == ST_PRESS_CHK) && (state_nx == ST_PRESSED);
        x_bit_nx      = step_nx ? x_s : x_bit;
        step_count_nx = step_nx ? step_count + 8'd1 : step_count;
        key_down_nx   = state_is_down(state_nx);
    end

endmodule
